// File: rtl/traffic_phase_scheduler.sv
// Demand-driven four-approach phase scheduler: round-robin green grants, emergency preempt,
// and tick-timed GREEN -> YELLOW -> ALL_RED sequencing driving the intersection light bus.
module traffic_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 20,
  parameter int unsigned GREEN_MAX = 40,
  parameter int unsigned YELLOW_T  = 5,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned CNT_W     = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [3:0]  req,
  input  logic        emerg_valid,
  input  logic [1:0]  emerg_dir,
  output logic [11:0] light,
  output logic [1:0]  active_dir,
  output logic        phase_done
);

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
  localparam logic [11:0]      ALL_RED_LIGHT = 12'h249;

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       rr_q, rr_d;
  logic [3:0]       pending_q, pending_d;
  logic [11:0]      light_q, light_d;
  logic             phase_done_q, phase_done_d;

  logic             grant_ok;
  logic [1:0]       grant_dir;
  logic [1:0]       cand;
  logic             other_pending;
  logic             hold;
  logic             emerg_other;
  logic             green_exit;

  assign light      = light_q;
  assign active_dir = dir_q;
  assign phase_done = phase_done_q;

  // Round-robin search from rr_q; iterating far-to-near lets the nearest set bit win.
  always_comb begin
    grant_ok  = 1'b0;
    grant_dir = 2'd0;
    cand      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_q + 2'(k);
      if (pending_q[cand]) begin
        grant_ok  = 1'b1;
        grant_dir = cand;
      end
    end
  end

  // The active approach's own demand never ends its green early; only other approaches count.
  always_comb begin
    other_pending = |(pending_q & ~(4'b0001 << dir_q));
    hold          = emerg_valid && (emerg_dir == dir_q);
    emerg_other   = emerg_valid && (emerg_dir != dir_q);
    green_exit    = emerg_other ||
                    (!hold && ((timer_q >= GMIN_LAST && (!req[dir_q] || other_pending)) ||
                               (timer_q == GMAX_LAST)));
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    dir_d        = dir_q;
    rr_d         = rr_q;
    pending_d    = pending_q | req;
    phase_done_d = 1'b0;

    if (tick) begin
      case (state_q)
        S_ALLRED: begin
          if (timer_q < AR_LAST) begin
            timer_d = timer_q + CNT_W'(1);
          end else if (emerg_valid) begin
            state_d              = S_GREEN;
            timer_d              = '0;
            dir_d                = emerg_dir;
            pending_d[emerg_dir] = req[emerg_dir];
          end else if (grant_ok) begin
            state_d              = S_GREEN;
            timer_d              = '0;
            dir_d                = grant_dir;
            rr_d                 = grant_dir + 2'd1;
            pending_d[grant_dir] = req[grant_dir];
          end
        end
        S_GREEN: begin
          if (green_exit) begin
            state_d = S_YELLOW;
            timer_d = '0;
          end else if (timer_q < GMAX_LAST) begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        S_YELLOW: begin
          if (timer_q == YEL_LAST) begin
            state_d      = S_ALLRED;
            timer_d      = '0;
            phase_done_d = 1'b1;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_ALLRED;
          timer_d = '0;
        end
      endcase
    end
  end

  // Light bus follows the next state so it changes on the same edge as the FSM.
  always_comb begin
    light_d = ALL_RED_LIGHT;
    for (int i = 0; i < 4; i++) begin
      if (dir_d == 2'(i) && state_d == S_GREEN) begin
        light_d[11-3*i -: 3] = 3'b100;
      end else if (dir_d == 2'(i) && state_d == S_YELLOW) begin
        light_d[11-3*i -: 3] = 3'b010;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_ALLRED;
      timer_q      <= '0;
      dir_q        <= 2'd0;
      rr_q         <= 2'd0;
      pending_q    <= 4'b0000;
      light_q      <= ALL_RED_LIGHT;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dir_q        <= dir_d;
      rr_q         <= rr_d;
      pending_q    <= pending_d;
      light_q      <= light_d;
      phase_done_q <= phase_done_d;
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: phase-level reference model checked every cycle,
// plus directed scenarios with hand-computed light codes and phase lengths.
module tb_traffic_phase_scheduler;

  localparam int GREEN_MIN = 20;
  localparam int GREEN_MAX = 40;
  localparam int YELLOW_T  = 5;
  localparam int ALLRED_T  = 2;

  localparam int PH_RED = 0;
  localparam int PH_GRN = 1;
  localparam int PH_YEL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic        emerg_valid = 1'b0;
  logic [1:0]  emerg_dir = 2'd0;
  logic [11:0] light;
  logic [1:0]  active_dir;
  logic        phase_done;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_phase_scheduler #(
    .GREEN_MIN(20), .GREEN_MAX(40), .YELLOW_T(5), .ALLRED_T(2), .CNT_W(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(req),
    .emerg_valid(emerg_valid), .emerg_dir(emerg_dir),
    .light(light), .active_dir(active_dir), .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] light_of(input int ph, input int dir);
    logic [11:0] r;
    logic [2:0]  f;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      f = 3'b001;
      if (i == dir && ph == PH_GRN) f = 3'b100;
      if (i == dir && ph == PH_YEL) f = 3'b010;
      r = r | (12'(f) << (9 - 3*i));
    end
    return r;
  endfunction

  function automatic int green_of(input logic [11:0] l);
    logic [2:0] f;
    for (int i = 0; i < 4; i++) begin
      f = l[11-3*i -: 3];
      if (f == 3'b100) return i;
    end
    return -1;
  endfunction

  // Reference model: phase, ticks elapsed in phase, owner, round-robin start, latched demand.
  int         m_ph = PH_RED;
  int         m_n = 0;
  int         m_dir = 0;
  int         m_rr = 0;
  logic [3:0] m_pend = 4'b0000;
  logic       m_done = 1'b0;
  int         nth;
  int         g;
  logic [3:0] pnext;
  logic       others;
  logic       hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = PH_RED; m_n = 0; m_dir = 0; m_rr = 0; m_pend = 4'b0000; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      pnext  = m_pend | req;
      if (tick) begin
        nth = m_n + 1;
        m_n = nth;
        case (m_ph)
          PH_RED: begin
            if (nth >= ALLRED_T) begin
              g = -1;
              if (emerg_valid) g = int'(emerg_dir);
              else
                for (int k = 0; k < 4; k++)
                  if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
              if (g >= 0) begin
                if (!emerg_valid) m_rr = (g + 1) % 4;
                m_dir    = g;
                pnext[g] = req[g];
                m_ph     = PH_GRN;
                m_n      = 0;
              end
            end
          end
          PH_GRN: begin
            others = 1'b0;
            for (int k = 0; k < 4; k++) if (k != m_dir && m_pend[k]) others = 1'b1;
            hold = emerg_valid && (int'(emerg_dir) == m_dir);
            if ((emerg_valid && !hold) ||
                (!hold && (nth >= GREEN_MAX ||
                           (nth >= GREEN_MIN && (!req[m_dir] || others))))) begin
              m_ph = PH_YEL;
              m_n  = 0;
            end
          end
          default: begin
            if (nth >= YELLOW_T) begin
              m_ph = PH_RED; m_n = 0; m_done = 1'b1;
            end
          end
        endcase
      end
      m_pend = pnext;
    end
  end

  always @(negedge clk) begin
    check("model_light", light, light_of(m_ph, m_dir));
    check("model_active_dir", 12'(active_dir), 12'(m_dir));
    check("model_phase_done", 12'(phase_done), 12'(m_done));
  end

  task automatic wait_until(input logic [11:0] v, input int maxc, input string nm);
    int k;
    k = 0;
    while (light !== v && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(nm, light, v);
  endtask

  task automatic run_len(input logic [11:0] v, output int n);
    n = 0;
    while (light === v && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 4'b0000; emerg_valid = 1'b0; emerg_dir = 2'd0; tick = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_req(input logic [3:0] r);
    req = r;
    @(negedge clk);
    req = 4'b0000;
  endtask

  int n;
  int k;
  int saw_done;
  int exp_dirs[5] = '{0, 1, 2, 3, 0};

  initial begin
    // T1: idle, all red, no phase_done
    do_reset();
    check("t1_reset_light", light, 12'h249);
    saw_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (phase_done) saw_done = 1;
    end
    check("t1_idle_light", light, 12'h249);
    check("t1_no_done", 12'(saw_done), 12'd0);

    // T2: single pulse on approach 2
    pulse_req(4'b0100);
    wait_until(12'h261, 10, "t2_green");
    check("t2_active", 12'(active_dir), 12'd2);
    run_len(12'h261, n);
    check("t2_green_len", 12'(n), 12'd20);
    check("t2_yellow", light, 12'h251);
    run_len(12'h251, n);
    check("t2_yellow_len", 12'(n), 12'd5);
    check("t2_done", 12'(phase_done), 12'd1);
    check("t2_allred", light, 12'h249);

    // T3: all approaches demanding, round-robin order
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      k = 0;
      while (green_of(light) < 0 && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("t3_green_dir", 12'(green_of(light)), 12'(exp_dirs[i]));
      run_len(light, n);
      check("t3_green_len", 12'(n), 12'd20);
      if (i < 4) begin
        k = 0;
        while (green_of(light) < 0 && k < 50) begin
          @(negedge clk);
          k++;
        end
        check("t3_gap_len", 12'(k), 12'd7);
      end
    end
    req = 4'b0000;

    // T4: held demand runs to max green; late competing pulse ends green next tick
    do_reset();
    req = 4'b0010;
    wait_until(12'h309, 10, "t4_green");
    run_len(12'h309, n);
    check("t4_max_len", 12'(n), 12'd40);
    check("t4_yellow", light, 12'h289);
    wait_until(12'h309, 20, "t4_regrant");
    repeat (24) @(negedge clk);
    req = 4'b1010;
    @(negedge clk);
    check("t4_still_green", light, 12'h309);
    req = 4'b0010;
    @(negedge clk);
    check("t4_early_yellow", light, 12'h289);
    wait_until(12'h24C, 20, "t4_dir3_green");
    req = 4'b0000;

    // T5: emergency preempt, hold beyond max green, round-robin pointer untouched
    do_reset();
    pulse_req(4'b0001);
    wait_until(12'h849, 10, "t5_green0");
    repeat (4) @(negedge clk);
    emerg_valid = 1'b1;
    emerg_dir   = 2'd3;
    @(negedge clk);
    check("t5_preempt_yellow", light, 12'h449);
    repeat (7) @(negedge clk);
    check("t5_emerg_green", light, 12'h24C);
    repeat (60) @(negedge clk);
    check("t5_hold_green", light, 12'h24C);
    emerg_valid = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    check("t5_release_yellow", light, 12'h24A);
    k = 0;
    while (green_of(light) < 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t5_rr_next_dir", 12'(green_of(light)), 12'd1);
    req = 4'b0000;

    // T6: async reset mid-yellow, then timing repeats; tick freeze mid-green
    do_reset();
    pulse_req(4'b0100);
    wait_until(12'h251, 40, "t6_yellow");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_light", light, 12'h249);
    check("t6_async_dir", 12'(active_dir), 12'd0);
    check("t6_async_done", 12'(phase_done), 12'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_req(4'b0100);
    wait_until(12'h261, 10, "t6_green");
    run_len(12'h261, n);
    check("t6_green_len", 12'(n), 12'd20);
    run_len(12'h251, n);
    check("t6_yellow_len", 12'(n), 12'd5);
    check("t6_done", 12'(phase_done), 12'd1);
    pulse_req(4'b0100);
    wait_until(12'h261, 10, "t6_green2");
    repeat (4) @(negedge clk);
    tick = 1'b0;
    repeat (50) @(negedge clk);
    check("t6_frozen_light", light, 12'h261);
    tick = 1'b1;
    run_len(12'h261, n);
    check("t6_resumed_len", 12'(n), 12'd16);
    check("t6_after_freeze_yellow", light, 12'h251);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
